// File: rtl/uart_bridge_pkg.sv
// Shared opcodes, reply codes and FSM state encoding for the UART-to-bus bridge.
package uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] RPL_ACK   = 8'h4B;
  localparam logic [7:0] RPL_ERR   = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ADDR       = 3'd1,
    S_DATA       = 3'd2,
    S_WR_ISSUE   = 3'd3,
    S_RD_ISSUE   = 3'd4,
    S_RD_CAPTURE = 3'd5,
    S_TX_SEND    = 3'd6,
    S_TX_WAIT    = 3'd7
  } state_t;

endpackage

// File: rtl/bridge_timeout.sv
// Inter-byte idle counter: restarts on kick, holds clear while disabled,
// and emits a one-cycle expired pulse after TIMEOUT_CYCLES quiet cycles.
module bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic kick,
  input  logic enable,
  output logic expired
);

  logic [31:0] count;

  // Count quiet cycles while enabled; fire once and restart at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (!enable || kick) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (count == 32'(TIMEOUT_CYCLES - 1)) begin
      count   <= '0;
      expired <= 1'b1;
    end else begin
      count   <= count + 32'd1;
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART byte-stream to 32-bit bus bridge: parses write/read packets, issues
// single-cycle bus strobes and streams the reply bytes back MSB first.
module uart_bus_master
  import uart_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [7:0]  rx_out,
  output logic        tx_en,
  output logic [7:0]  tx_in,
  input  logic        tx_done,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] Read_data,
  output logic        busy,
  output logic        overrun
);

  state_t      state;
  logic        is_read;
  logic [1:0]  byte_cnt;
  logic [31:0] reply;
  logic [2:0]  reply_cnt;
  logic        tmo_en;
  logic        expired;
  logic        drop_state;

  assign tmo_en     = (state == S_ADDR) || (state == S_DATA);
  assign busy       = (state != S_IDLE);
  assign drop_state = (state == S_WR_ISSUE) || (state == S_RD_ISSUE) ||
                      (state == S_RD_CAPTURE) || (state == S_TX_SEND) ||
                      (state == S_TX_WAIT);

  bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .kick   (rx_done),
    .enable (tmo_en),
    .expired(expired)
  );

  // Packet parser, bus sequencer and reply streamer with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      is_read    <= 1'b0;
      byte_cnt   <= '0;
      reply      <= '0;
      reply_cnt  <= '0;
      Address    <= '0;
      Write_data <= '0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
      tx_en      <= 1'b0;
      tx_in      <= '0;
      overrun    <= 1'b0;
    end else begin
      MemWrite <= 1'b0;
      MemRead  <= 1'b0;
      tx_en    <= 1'b0;
      // A byte arriving while the bridge is busy with the bus or reply is lost.
      if (rx_done && drop_state) overrun <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (rx_done) begin
            if (rx_out == OP_WRITE || rx_out == OP_READ) begin
              is_read  <= (rx_out == OP_READ);
              byte_cnt <= '0;
              state    <= S_ADDR;
            end else begin
              reply     <= {RPL_ERR, 24'h0};
              reply_cnt <= 3'd1;
              state     <= S_TX_SEND;
            end
          end
        end
        S_ADDR: begin
          if (rx_done) begin
            Address  <= {Address[23:0], rx_out};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_read) begin
                MemRead <= 1'b1;
                state   <= S_RD_ISSUE;
              end else begin
                state <= S_DATA;
              end
            end
          end else if (expired) begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (rx_done) begin
            Write_data <= {Write_data[23:0], rx_out};
            byte_cnt   <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              MemWrite <= 1'b1;
              state    <= S_WR_ISSUE;
            end
          end else if (expired) begin
            state <= S_IDLE;
          end
        end
        S_WR_ISSUE: begin
          reply     <= {RPL_ACK, 24'h0};
          reply_cnt <= 3'd1;
          state     <= S_TX_SEND;
        end
        S_RD_ISSUE: begin
          state <= S_RD_CAPTURE;
        end
        S_RD_CAPTURE: begin
          reply     <= Read_data;
          reply_cnt <= 3'd4;
          state     <= S_TX_SEND;
        end
        S_TX_SEND: begin
          tx_in <= reply[31:24];
          tx_en <= 1'b1;
          state <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (tx_done) begin
            if (reply_cnt > 3'd1) begin
              reply     <= {reply[23:0], 8'h00};
              reply_cnt <= reply_cnt - 3'd1;
              state     <= S_TX_SEND;
            end else begin
              reply_cnt <= '0;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
